// File: rtl/mod8_sequence_checker.sv
// Sequence monitor for a free-running modulo-2^WIDTH counter: locks onto the stream,
// tracks wraps and mismatches, and latches a sticky fault after ERR_LIMIT consecutive errors.
module mod8_sequence_checker #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             sample_en,
  input  logic             clr,
  output logic             locked,
  output logic             fault,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {StIdle, StSync, StLocked, StFault} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic [7:0]       run_q, run_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  logic             err_pulse_q, err_pulse_d;

  logic [WIDTH-1:0] cnt_inc;
  logic [8:0]       run_inc;
  logic             match, is_zero, limit_hit;

  assign cnt_inc   = cnt_in + WIDTH'(1);
  assign match     = (cnt_in == expected_q);
  assign is_zero   = (cnt_in == '0);
  // ERR_LIMIT is at most 255, so a 9-bit compare never aliases.
  assign run_inc   = {1'b0, run_q} + 9'd1;
  assign limit_hit = (run_inc == 9'(ERR_LIMIT));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q      <= StIdle;
      expected_q   <= '0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
      run_q        <= '0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
      err_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      run_q        <= run_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sample_en) begin
      unique case (state_q)
        StIdle:   state_d = StSync;
        StSync:   if (match) state_d = StLocked;
        StLocked: if (!match && limit_hit) state_d = StFault;
        StFault:  state_d = StFault;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    expected_d   = expected_q;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    run_d        = run_q;
    locked_d     = locked_q;
    fault_d      = fault_q;
    err_pulse_d  = 1'b0;
    if (sample_en) begin
      unique case (state_q)
        StIdle: expected_d = cnt_inc;
        StSync: begin
          expected_d = cnt_inc;
          if (match) begin
            locked_d = 1'b1;
            if (is_zero && wrap_count_q != '1) wrap_count_d = wrap_count_q + CNT_W'(1);
          end
        end
        StLocked: begin
          expected_d = cnt_inc;
          if (match) begin
            run_d = '0;
            if (is_zero && wrap_count_q != '1) wrap_count_d = wrap_count_q + CNT_W'(1);
          end else begin
            err_pulse_d = 1'b1;
            run_d       = run_inc[7:0];
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
            if (limit_hit) begin
              locked_d = 1'b0;
              fault_d  = 1'b1;
            end
          end
        end
        StFault: ;
        default: ;
      endcase
    end
  end

  assign locked     = locked_q;
  assign fault      = fault_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_mod8_sequence_checker.sv
// Scoreboard bench: stimulus pushes hand-computed expected outputs, a monitor pops and compares.
module tb_mod8_sequence_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1, clr = 1'b0, sample_en = 1'b0;
  logic [2:0] cnt_in = '0;
  logic       locked, fault, err_pulse;
  logic [7:0] err_count, wrap_count;
  logic [2:0] expected;

  logic       rst2 = 1'b1, clr2 = 1'b0, sample_en2 = 1'b0;
  logic [2:0] cnt_in2 = '0;
  logic       locked2, fault2, err_pulse2;
  logic [1:0] err_count2, wrap_count2;
  logic [2:0] expected2;

  always #5 clk = ~clk;

  mod8_sequence_checker #(.WIDTH(3), .CNT_W(8), .ERR_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .sample_en(sample_en), .clr(clr),
    .locked(locked), .fault(fault), .err_pulse(err_pulse), .err_count(err_count),
    .wrap_count(wrap_count), .expected(expected)
  );

  mod8_sequence_checker #(.WIDTH(3), .CNT_W(2), .ERR_LIMIT(3)) dut2 (
    .clk(clk), .rst(rst2), .cnt_in(cnt_in2), .sample_en(sample_en2), .clr(clr2),
    .locked(locked2), .fault(fault2), .err_pulse(err_pulse2), .err_count(err_count2),
    .wrap_count(wrap_count2), .expected(expected2)
  );

  typedef struct {
    int         id;
    logic       sel;
    logic       l, f, p;
    logic [7:0] ec, wc;
    logic [2:0] ex;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_id = 0;

  task automatic check(input string name, input int id, input logic [7:0] act,
                       input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h, want %0h", name, id, act, req);
    end
  endtask

  // Monitor: outputs are registered, so every edge presents a fresh response.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.sel) begin
        check("locked", e.id, {7'd0, locked}, {7'd0, e.l});
        check("fault", e.id, {7'd0, fault}, {7'd0, e.f});
        check("err_pulse", e.id, {7'd0, err_pulse}, {7'd0, e.p});
        check("err_count", e.id, err_count, e.ec);
        check("wrap_count", e.id, wrap_count, e.wc);
        check("expected", e.id, {5'd0, expected}, {5'd0, e.ex});
      end else begin
        check("locked2", e.id, {7'd0, locked2}, {7'd0, e.l});
        check("fault2", e.id, {7'd0, fault2}, {7'd0, e.f});
        check("err_pulse2", e.id, {7'd0, err_pulse2}, {7'd0, e.p});
        check("err_count2", e.id, {6'd0, err_count2}, e.ec);
        check("wrap_count2", e.id, {6'd0, wrap_count2}, e.wc);
        check("expected2", e.id, {5'd0, expected2}, {5'd0, e.ex});
      end
    end
  end

  task automatic step(input logic sel, input logic r, input logic c, input logic en,
                      input logic [2:0] v, input logic l, input logic f, input logic p,
                      input logic [7:0] ec, input logic [7:0] wc, input logic [2:0] ex);
    exp_t e;
    @(negedge clk);
    if (!sel) begin
      rst = r; clr = c; sample_en = en; cnt_in = v;
    end else begin
      rst2 = r; clr2 = c; sample_en2 = en; cnt_in2 = v;
    end
    e.id = vec_id++; e.sel = sel; e.l = l; e.f = f; e.p = p;
    e.ec = ec; e.wc = wc; e.ex = ex;
    sb.push_back(e);
  endtask

  initial begin
    // Reset with sample_en high and a toggling count
    step(0, 1, 0, 1, 3'd5, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 3'd2, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0);
    // Clean stream 3..1: lock at 4, wrap at 0
    step(0, 0, 0, 1, 3'd3, 0, 0, 0, 0, 0, 4);
    step(0, 0, 0, 1, 3'd4, 1, 0, 0, 0, 0, 5);
    step(0, 0, 0, 1, 3'd5, 1, 0, 0, 0, 0, 6);
    step(0, 0, 0, 1, 3'd6, 1, 0, 0, 0, 0, 7);
    step(0, 0, 0, 1, 3'd7, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd0, 1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 3'd1, 1, 0, 0, 0, 1, 2);
    // Single glitch: 2,3,6,7,0
    step(0, 0, 0, 1, 3'd2, 1, 0, 0, 0, 1, 3);
    step(0, 0, 0, 1, 3'd3, 1, 0, 0, 0, 1, 4);
    step(0, 0, 0, 1, 3'd6, 1, 0, 1, 1, 1, 7);
    step(0, 0, 0, 1, 3'd7, 1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 3'd0, 1, 0, 0, 1, 2, 1);
    // Reach expected=4, pause five cycles, resume
    step(0, 0, 0, 1, 3'd1, 1, 0, 0, 1, 2, 2);
    step(0, 0, 0, 1, 3'd2, 1, 0, 0, 1, 2, 3);
    step(0, 0, 0, 1, 3'd3, 1, 0, 0, 1, 2, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 3'd4, 1, 0, 0, 1, 2, 4);
    step(0, 0, 0, 1, 3'd4, 1, 0, 0, 1, 2, 5);
    step(0, 0, 0, 1, 3'd5, 1, 0, 0, 1, 2, 6);
    // Repeated value is a mismatch; a match clears the consecutive run
    step(0, 0, 0, 1, 3'd6, 1, 0, 0, 1, 2, 7);
    step(0, 0, 0, 1, 3'd6, 1, 0, 1, 2, 2, 7);
    step(0, 0, 0, 1, 3'd7, 1, 0, 0, 2, 2, 0);
    step(0, 0, 0, 1, 3'd3, 1, 0, 1, 3, 2, 4);
    step(0, 0, 0, 1, 3'd1, 1, 0, 1, 4, 2, 2);
    step(0, 0, 0, 1, 3'd2, 1, 0, 0, 4, 2, 3);
    step(0, 0, 0, 1, 3'd5, 1, 0, 1, 5, 2, 6);
    step(0, 0, 0, 1, 3'd6, 1, 0, 0, 5, 2, 7);
    step(0, 0, 0, 1, 3'd7, 1, 0, 0, 5, 2, 0);
    // 0,5,(pause),2,7: third consecutive mismatch faults; pause keeps the run
    step(0, 0, 0, 1, 3'd0, 1, 0, 0, 5, 3, 1);
    step(0, 0, 0, 1, 3'd5, 1, 0, 1, 6, 3, 6);
    step(0, 0, 0, 0, 3'd5, 1, 0, 0, 6, 3, 6);
    step(0, 0, 0, 1, 3'd2, 1, 0, 1, 7, 3, 3);
    step(0, 0, 0, 1, 3'd7, 0, 1, 1, 8, 3, 0);
    step(0, 0, 0, 1, 3'd3, 0, 1, 0, 8, 3, 0);
    step(0, 0, 0, 1, 3'd0, 0, 1, 0, 8, 3, 0);
    // clr with sample_en discards the sample
    step(0, 0, 1, 1, 3'd5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd6, 0, 0, 0, 0, 0, 7);
    step(0, 0, 0, 1, 3'd6, 0, 0, 0, 0, 0, 7);
    step(0, 0, 0, 1, 3'd7, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd0, 1, 0, 0, 0, 1, 1);
    // rst and clr together, then relock
    step(0, 1, 1, 1, 3'd1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd4, 0, 0, 0, 0, 0, 5);
    step(0, 0, 0, 1, 3'd5, 1, 0, 0, 0, 0, 6);
    step(0, 0, 0, 0, 3'd5, 1, 0, 0, 0, 0, 6);

    // CNT_W=2 instance: wrap_count saturates at 3
    step(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      int wc;
      wc = (k / 8 > 3) ? 3 : k / 8;
      step(1, 0, 0, 1, 3'(k % 8), (k >= 1), 0, 0, 0, 8'(wc), 3'((k + 1) % 8));
    end
    step(1, 1, 0, 1, 3'd0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 3'd3, 0, 0, 0, 0, 0, 4);
    step(1, 0, 0, 1, 3'd4, 1, 0, 0, 0, 0, 5);

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
